// File: rtl/prescaler_pkg.sv
// -----------------------------------------------------------------------------
// prescaler_pkg
// Shared types and defaults for the multi-channel clock-enable generator.
//   mode_e       : per-channel run mode (stop / continuous / burst / reserved)
//   lane_state_e : per-lane run state (IDLE / RUN)
//   DEF_WIDTH    : default factor/counter width
//   DEF_BURST_W  : default burst length counter width
// -----------------------------------------------------------------------------
package prescaler_pkg;

    localparam int unsigned DEF_WIDTH   = 29;
    localparam int unsigned DEF_BURST_W = 16;

    typedef enum logic [1:0] {
        MODE_STOP  = 2'b00,
        MODE_CONT  = 2'b01,
        MODE_BURST = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lane_state_e;

endpackage

// File: rtl/prescaler_multi_lane.sv
// -----------------------------------------------------------------------------
// prescaler_lane
// One clock-enable channel: down-counter, pending/active factor handshake,
// burst counter and a two-state run FSM.
// Optional feature macro: PRESCALER_PHASE_EN (adds phase, used as the counter
// load value at the start edge and on sync).
// Ports:
//   clk, rst        : system clock, asynchronous active-low reset
//   en, mode        : run enable and run mode
//   factor,
//   factor_load     : new factor and its 1-cycle capture request
//   factor_ack      : 1-cycle pulse when the pending factor becomes active
//   burst_len, start: burst length and 1-cycle burst start
//   sync            : phase-align request
//   phase           : start/sync counter load (PRESCALER_PHASE_EN only)
//   busy, ce        : channel running, registered clock-enable pulse
// -----------------------------------------------------------------------------
module prescaler_lane
    import prescaler_pkg::*;
#(
    parameter int unsigned          WIDTH        = DEF_WIDTH,
    parameter int unsigned          BURST_W      = DEF_BURST_W,
    parameter logic [WIDTH-1:0]     RESET_FACTOR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   factor,
    input  logic               factor_load,
    output logic               factor_ack,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               start,
    input  logic               sync,
`ifdef PRESCALER_PHASE_EN
    input  logic [WIDTH-1:0]   phase,
`endif
    output logic               busy,
    output logic               ce
);

    localparam logic [WIDTH-1:0]   CNT_ONE   = WIDTH'(1);
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

    lane_state_e        state_q, state_d;
    mode_e              run_mode_q, run_mode_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   active_q, active_d;
    logic [WIDTH-1:0]   pend_q, pend_d;
    logic               pend_valid_q, pend_valid_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               ce_q, ce_d;
    logic               ack_q, ack_d;

    mode_e              mode_s;
    logic               adopt_s;
    logic               cont_go_s;
    logic               burst_go_s;
    logic               stop_s;
    logic [WIDTH-1:0]   fac_next_s;
    logic [WIDTH-1:0]   start_val_s;

    assign mode_s     = mode_e'(mode);
    // Factor in force after this edge: pending wins so a period never mixes values.
    assign fac_next_s = pend_valid_q ? pend_q : active_q;
    assign cont_go_s  = en && (mode_s == MODE_CONT);
    assign burst_go_s = start && en && (mode_s == MODE_BURST) && (burst_len != '0);
    // Any mode change while running (including to reserved) stops the lane.
    assign stop_s     = !en || (mode_s != run_mode_q);

`ifdef PRESCALER_PHASE_EN
    assign start_val_s = phase;
`else
    assign start_val_s = fac_next_s;
`endif

    // Next-state logic: run FSM, counter, burst counter and factor handshake.
    always_comb begin
        state_d      = state_q;
        run_mode_d   = run_mode_q;
        cnt_d        = cnt_q;
        active_d     = active_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        burst_d      = burst_q;
        ce_d         = 1'b0;
        ack_d        = 1'b0;
        adopt_s      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cont_go_s || burst_go_s) begin
                    state_d    = RUN;
                    run_mode_d = mode_s;
                    adopt_s    = pend_valid_q;
                    cnt_d      = start_val_s;
                    burst_d    = burst_go_s ? burst_len : '0;
                end else begin
                    // Idle adoption waits while loads keep arriving, so
                    // back-to-back loads collapse into a single ack.
                    adopt_s = pend_valid_q && !factor_load;
                end
            end
            RUN: begin
                if (stop_s || ((run_mode_q == MODE_BURST) && (burst_q == '0))) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    burst_d = '0;
                end else if (sync) begin
                    adopt_s = pend_valid_q;
                    cnt_d   = start_val_s;
                end else if (cnt_q == '0) begin
                    adopt_s = pend_valid_q;
                    cnt_d   = fac_next_s;
                    ce_d    = 1'b1;
                    if (run_mode_q == MODE_BURST) begin
                        burst_d = burst_q - BURST_ONE;
                    end else begin
                        burst_d = burst_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                burst_d = '0;
            end
        endcase

        if (adopt_s) begin
            active_d = pend_q;
            ack_d    = 1'b1;
        end else begin
            active_d = active_q;
        end

        // A load on the adoption edge becomes the new pending value.
        if (factor_load) begin
            pend_d       = factor;
            pend_valid_d = 1'b1;
        end else if (adopt_s) begin
            pend_valid_d = 1'b0;
        end else begin
            pend_valid_d = pend_valid_q;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            run_mode_q   <= MODE_STOP;
            cnt_q        <= '0;
            active_q     <= RESET_FACTOR;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            burst_q      <= '0;
            ce_q         <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_mode_q   <= run_mode_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            burst_q      <= burst_d;
            ce_q         <= ce_d;
            ack_q        <= ack_d;
        end
    end

    assign ce         = ce_q;
    assign factor_ack = ack_q;
    assign busy       = (state_q == RUN);

endmodule

// File: rtl/prescaler_multi.sv
// -----------------------------------------------------------------------------
// prescaler_multi
// Multi-channel programmable clock-enable generator: NUM_CH independent lanes
// sharing one clock, with a global phase-align sync fanned out to every lane.
// Optional feature macro: PRESCALER_PHASE_EN (adds per-channel phase port).
// Ports (per-channel buses are packed, channel c at [c*W +: W]):
//   clk, rst          : system clock, asynchronous active-low reset
//   en, mode          : per-channel enable / 2-bit mode
//   factor,factor_load: per-channel new factor and capture request
//   factor_ack        : per-channel adoption pulse
//   burst_len, start  : per-channel burst length and start pulse
//   sync              : global phase-align
//   phase             : per-channel start phase (PRESCALER_PHASE_EN only)
//   busy, ce          : per-channel running flag and clock-enable
// -----------------------------------------------------------------------------
module prescaler_multi
    import prescaler_pkg::*;
#(
    parameter int unsigned      WIDTH        = DEF_WIDTH,
    parameter int unsigned      NUM_CH       = 2,
    parameter int unsigned      BURST_W      = DEF_BURST_W,
    parameter logic [WIDTH-1:0] RESET_FACTOR = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         en,
    input  logic [2*NUM_CH-1:0]       mode,
    input  logic [NUM_CH*WIDTH-1:0]   factor,
    input  logic [NUM_CH-1:0]         factor_load,
    output logic [NUM_CH-1:0]         factor_ack,
    input  logic [NUM_CH*BURST_W-1:0] burst_len,
    input  logic [NUM_CH-1:0]         start,
    input  logic                      sync,
`ifdef PRESCALER_PHASE_EN
    input  logic [NUM_CH*WIDTH-1:0]   phase,
`endif
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         ce
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        prescaler_lane #(
            .WIDTH        (WIDTH),
            .BURST_W      (BURST_W),
            .RESET_FACTOR (RESET_FACTOR)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .en          (en[g]),
            .mode        (mode[2*g +: 2]),
            .factor      (factor[g*WIDTH +: WIDTH]),
            .factor_load (factor_load[g]),
            .factor_ack  (factor_ack[g]),
            .burst_len   (burst_len[g*BURST_W +: BURST_W]),
            .start       (start[g]),
            .sync        (sync),
`ifdef PRESCALER_PHASE_EN
            .phase       (phase[g*WIDTH +: WIDTH]),
`endif
            .busy        (busy[g]),
            .ce          (ce[g])
        );
    end

endmodule
